// File: rtl/rv32_pkg.sv
// Shared RV32 fetch-path constants and the fetch FSM state type.
package rv32_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_FAULT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory channel, redirect input and output register.
interface fetch_unit_if
    import rv32_pkg::*;
();

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic            fault;
    logic [XLEN-1:0] perf_fetched;
    logic [XLEN-1:0] perf_killed;

    modport master (
        output imem_req_valid, imem_addr, out_valid, out_pc, out_instr, fault,
               perf_fetched, perf_killed,
        input  imem_req_ready, imem_rsp_valid, imem_rdata, redirect_valid,
               redirect_target, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, out_valid, out_pc, out_instr, fault,
               perf_fetched, perf_killed,
        output imem_req_ready, imem_rsp_valid, imem_rdata, redirect_valid,
               redirect_target, out_ready
    );

endinterface

// File: rtl/sat_counter.sv
// XLEN-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter
    import rv32_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    output logic [XLEN-1:0] count_o
);

    logic [XLEN-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (en_i && (count_q != '1)) begin
            count_q <= count_q + XLEN'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, one-outstanding imem request, one-entry output register.
// Define FETCH_PERF_EN to build the fetched/killed saturating counters; otherwise they read 0.
module fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inflight_q, inflight_d;
    logic            kill_q, kill_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] out_instr_q, out_instr_d;
    logic            fault_q, fault_d;

    logic req_valid_c;
    logic req_accept_c;
    logic rsp_c;

    assign req_valid_c  = (state_q == S_REQ) && (!out_valid_q || bus.out_ready);
    assign req_accept_c = req_valid_c && bus.imem_req_ready;
    assign rsp_c        = (state_q == S_WAIT) && bus.imem_rsp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            inflight_q  <= '0;
            kill_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= INSTR_NOP;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inflight_q  <= inflight_d;
            kill_q      <= kill_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            fault_q     <= fault_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inflight_d  = inflight_q;
        kill_d      = kill_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        fault_d     = fault_q;

        case (state_q)
            S_REQ: begin
                if (req_accept_c) begin
                    inflight_d = pc_q;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    state_d = S_REQ;
                    if (kill_q) begin
                        kill_d = 1'b0;
                    end else begin
                        out_valid_d = 1'b1;
                        out_pc_d    = inflight_q;
                        out_instr_d = bus.imem_rdata;
                        pc_d        = inflight_q + PC_STEP;
                    end
                end
            end
            S_FAULT: begin
                out_valid_d = 1'b0;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        // Redirect wins over everything above; a fetch still on the bus must be drained and dropped.
        if (bus.redirect_valid && (state_q != S_FAULT)) begin
            out_valid_d = 1'b0;
            out_pc_d    = out_pc_q;
            out_instr_d = out_instr_q;
            pc_d        = pc_q;
            if (bus.redirect_target[1:0] != 2'b00) begin
                fault_d = 1'b1;
                kill_d  = 1'b0;
                state_d = S_FAULT;
            end else begin
                pc_d = bus.redirect_target;
                if (((state_q == S_WAIT) && !rsp_c) || req_accept_c) begin
                    kill_d  = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    kill_d  = 1'b0;
                    state_d = S_REQ;
                end
            end
        end
    end

    assign bus.imem_req_valid = req_valid_c;
    assign bus.imem_addr      = pc_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_pc         = out_pc_q;
    assign bus.out_instr      = out_instr_q;
    assign bus.fault          = fault_q;

`ifdef FETCH_PERF_EN
    logic            fetched_c;
    logic            killed_c;
    logic [XLEN-1:0] perf_fetched;
    logic [XLEN-1:0] perf_killed;

    assign fetched_c = rsp_c && !kill_q && !bus.redirect_valid;
    assign killed_c  = rsp_c && (kill_q || bus.redirect_valid);

    sat_counter u_fetched_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (fetched_c),
        .count_o (perf_fetched)
    );

    sat_counter u_killed_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (killed_c),
        .count_o (perf_killed)
    );

    assign bus.perf_fetched = perf_fetched;
    assign bus.perf_killed  = perf_killed;
`else
    assign bus.perf_fetched = '0;
    assign bus.perf_killed  = '0;
`endif

endmodule
